// File: rtl/ex_stage_pkg.sv
// Shared opcode, run-state and payload definitions for the execute stage.
package ex_stage_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned OP_W    = 5;
    localparam int unsigned SHAMT_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 5'd0,
        OP_HALT  = 5'd1,
        OP_LOAD  = 5'd2,
        OP_STORE = 5'd3,
        OP_LDIH  = 5'd8,
        OP_ADD   = 5'd9,
        OP_ADDI  = 5'd10,
        OP_ADDC  = 5'd11,
        OP_SUB   = 5'd12,
        OP_SUBI  = 5'd13,
        OP_SUBC  = 5'd14,
        OP_CMP   = 5'd15,
        OP_AND   = 5'd16,
        OP_OR    = 5'd17,
        OP_XOR   = 5'd18,
        OP_SLL   = 5'd19,
        OP_SRL   = 5'd20,
        OP_SLA   = 5'd21,
        OP_SRA   = 5'd22,
        OP_JMPR  = 5'd24,
        OP_BZ    = 5'd26,
        OP_BNZ   = 5'd27,
        OP_BN    = 5'd28,
        OP_BNN   = 5'd29,
        OP_BC    = 5'd30,
        OP_BNC   = 5'd31
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } run_state_e;

    typedef struct packed {
        logic zf;
        logic nf;
        logic cf;
    } flags_t;

    // Payload handed to the memory stage
    typedef struct packed {
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] smdr;
        logic              dw;
    } ex_mem_t;

    // Arithmetic, logic and shift ops write zf/nf
    function automatic logic sets_zn(op_e op);
        case (op)
            OP_ADD, OP_ADDI, OP_ADDC, OP_LDIH,
            OP_SUB, OP_SUBI, OP_SUBC, OP_CMP,
            OP_AND, OP_OR, OP_XOR,
            OP_SLL, OP_SRL, OP_SLA, OP_SRA: sets_zn = 1'b1;
            default:                        sets_zn = 1'b0;
        endcase
    endfunction

    // Only adds and subtracts write cf
    function automatic logic sets_cf(op_e op);
        case (op)
            OP_ADD, OP_ADDI, OP_ADDC, OP_LDIH,
            OP_SUB, OP_SUBI, OP_SUBC, OP_CMP: sets_cf = 1'b1;
            default:                          sets_cf = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 16-bit ALU: sums carry 17 bits, bit 16 is carry-out or borrow.
module alu16
    import ex_stage_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] result,
    output logic              cout
);

    logic [DATA_W:0]    sum;
    logic [DATA_W-1:0]  shl;
    logic [SHAMT_W-1:0] n;

    assign n   = b[SHAMT_W-1:0];
    assign shl = a << n;

    // Result and carry/borrow selection by opcode; unknown ops yield 0
    always_comb begin
        sum    = '0;
        result = '0;
        cout   = 1'b0;
        case (op)
            OP_ADD, OP_ADDI, OP_LDIH,
            OP_LOAD, OP_STORE, OP_JMPR,
            OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_W-1:0];
                cout   = sum[DATA_W];
            end
            OP_ADDC: begin
                sum    = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(cin);
                result = sum[DATA_W-1:0];
                cout   = sum[DATA_W];
            end
            OP_SUB, OP_SUBI, OP_CMP: begin
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[DATA_W-1:0];
                cout   = sum[DATA_W];
            end
            OP_SUBC: begin
                sum    = {1'b0, a} - {1'b0, b} - (DATA_W+1)'(cin);
                result = sum[DATA_W-1:0];
                cout   = sum[DATA_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SLL: result = shl;
            OP_SRL: result = a >> n;
            OP_SLA: result = {a[DATA_W-1], shl[DATA_W-2:0]};
            OP_SRA: result = DATA_W'($signed(a) >>> n);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: flag register, branch resolution and EX/MEM pipeline registers.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W   // only 16 is supported
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             state,
    input  logic [WIDTH-1:0] ex_ir,
    input  logic [WIDTH-1:0] reg_A,
    input  logic [WIDTH-1:0] reg_B,
    input  logic [WIDTH-1:0] smdr,
    output logic [WIDTH-1:0] mem_ir,
    output logic [WIDTH-1:0] reg_C,
    output logic [WIDTH-1:0] smdr1,
    output logic             dw,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output logic             branch_flag
);

    op_e              op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cout;
    logic             take_c;

    ex_mem_t pipe_q, pipe_d;
    flags_t  flags_q, flags_d;
    logic    branch_q, branch_d;

    assign op = op_e'(ex_ir[WIDTH-1 -: OP_W]);

    alu16 u_alu (
        .op     (op),
        .a      (reg_A),
        .b      (reg_B),
        .cin    (flags_q.cf),
        .result (alu_result),
        .cout   (alu_cout)
    );

    // Branch condition evaluated against flags left by the previous instruction
    always_comb begin
        take_c = 1'b0;
        case (op)
            OP_BZ:   take_c = flags_q.zf;
            OP_BNZ:  take_c = ~flags_q.zf;
            OP_BN:   take_c = flags_q.nf;
            OP_BNN:  take_c = ~flags_q.nf;
            OP_BC:   take_c = flags_q.cf;
            OP_BNC:  take_c = ~flags_q.cf;
            OP_JMPR: take_c = 1'b1;
            default: take_c = 1'b0;
        endcase
    end

    // Next state: hold when not running, squash the wrong-path slot, otherwise execute
    always_comb begin
        pipe_d   = pipe_q;
        flags_d  = flags_q;
        branch_d = branch_q;
        if (state == ST_EXEC) begin
            if (branch_q) begin
                pipe_d.ir   = '0;
                pipe_d.c    = '0;
                pipe_d.smdr = smdr;
                pipe_d.dw   = 1'b0;
                branch_d    = 1'b0;
            end else begin
                pipe_d.ir   = ex_ir;
                pipe_d.c    = alu_result;
                pipe_d.smdr = smdr;
                pipe_d.dw   = (op == OP_STORE);
                branch_d    = take_c;
                if (sets_zn(op)) begin
                    flags_d.zf = (alu_result == '0);
                    flags_d.nf = alu_result[WIDTH-1];
                end
                if (sets_cf(op)) begin
                    flags_d.cf = alu_cout;
                end
            end
        end
    end

    // Stage registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_q   <= '0;
            flags_q  <= '0;
            branch_q <= 1'b0;
        end else begin
            pipe_q   <= pipe_d;
            flags_q  <= flags_d;
            branch_q <= branch_d;
        end
    end

    assign mem_ir      = pipe_q.ir;
    assign reg_C       = pipe_q.c;
    assign smdr1       = pipe_q.smdr;
    assign dw          = pipe_q.dw;
    assign zf          = flags_q.zf;
    assign nf          = flags_q.nf;
    assign cf          = flags_q.cf;
    assign branch_flag = branch_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: reference model pushes expectations, monitor pops and compares.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        state;
    logic [15:0] ex_ir, reg_A, reg_B, smdr;
    logic [15:0] mem_ir, reg_C, smdr1;
    logic        dw, zf, nf, cf, branch_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] ir, c, sd;
        logic        dw, zf, nf, cf, bf, sq;
    } exp_t;

    exp_t q[$];
    exp_t m;

    localparam int NOPS = 26;
    logic [4:0] ops [NOPS] = '{OP_NOP, OP_HALT, OP_LOAD, OP_STORE, OP_LDIH, OP_ADD, OP_ADDI,
                               OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP, OP_AND, OP_OR,
                               OP_XOR, OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_JMPR, OP_BZ,
                               OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC};

    ex_stage dut (
        .clock       (clock),
        .reset       (reset),
        .state       (state),
        .ex_ir       (ex_ir),
        .reg_A       (reg_A),
        .reg_B       (reg_B),
        .smdr        (smdr),
        .mem_ir      (mem_ir),
        .reg_C       (reg_C),
        .smdr1       (smdr1),
        .dw          (dw),
        .zf          (zf),
        .nf          (nf),
        .cf          (cf),
        .branch_flag (branch_flag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: architectural effect of one clock edge
    function automatic exp_t model_step(exp_t cur, logic st, logic [15:0] ir,
                                        logic [15:0] a, logic [15:0] b, logic [15:0] sd);
        exp_t nx;
        int ua, ub, ci, r, n, sa;
        bit zn, cyu, cy, taken;
        nx    = cur;
        nx.sq = 1'b0;
        if (st !== 1'b1) return nx;
        if (cur.bf) begin
            nx.ir = 16'h0; nx.c = 16'h0; nx.sd = sd;
            nx.dw = 1'b0;  nx.bf = 1'b0; nx.sq = 1'b1;
            return nx;
        end
        ua = int'(a); ub = int'(b); ci = cur.cf ? 1 : 0; n = int'(b[3:0]);
        r = 0; zn = 0; cyu = 0; cy = 0; taken = 0;
        case (ir[15:11])
            OP_ADD, OP_ADDI, OP_LDIH: begin r = ua + ub; zn = 1; cyu = 1; cy = (r > 65535); end
            OP_ADDC: begin r = ua + ub + ci; zn = 1; cyu = 1; cy = (r > 65535); end
            OP_SUB, OP_SUBI, OP_CMP: begin r = ua - ub; zn = 1; cyu = 1; cy = (ua < ub); end
            OP_SUBC: begin r = ua - ub - ci; zn = 1; cyu = 1; cy = (ua < ub + ci); end
            OP_AND: begin r = ua & ub; zn = 1; end
            OP_OR:  begin r = ua | ub; zn = 1; end
            OP_XOR: begin r = ua ^ ub; zn = 1; end
            OP_SLL: begin r = ua << n; zn = 1; end
            OP_SRL: begin r = ua >> n; zn = 1; end
            OP_SLA: begin r = (ua & 32'h8000) | ((ua << n) & 32'h7FFF); zn = 1; end
            OP_SRA: begin sa = (ua >= 32768) ? ua - 65536 : ua; r = sa >>> n; zn = 1; end
            OP_LOAD, OP_STORE, OP_JMPR: r = ua + ub;
            OP_BZ:  begin r = ua + ub; taken = cur.zf; end
            OP_BNZ: begin r = ua + ub; taken = !cur.zf; end
            OP_BN:  begin r = ua + ub; taken = cur.nf; end
            OP_BNN: begin r = ua + ub; taken = !cur.nf; end
            OP_BC:  begin r = ua + ub; taken = cur.cf; end
            OP_BNC: begin r = ua + ub; taken = !cur.cf; end
            default: r = 0;
        endcase
        if (ir[15:11] == OP_JMPR) taken = 1;
        r = r & 32'hFFFF;
        nx.c = r[15:0];
        if (zn) begin nx.zf = (r == 0); nx.nf = r[15]; end
        if (cyu) nx.cf = cy;
        nx.ir = ir;
        nx.sd = sd;
        nx.dw = (ir[15:11] == OP_STORE);
        nx.bf = taken;
        return nx;
    endfunction

    // Model advances at each edge and queues the expected post-edge outputs
    always @(posedge clock) begin
        if (reset) m = '{default: 0};
        else       m = model_step(m, state, ex_ir, reg_A, reg_B, smdr);
        q.push_back(m);
    end

    // Asynchronous reset clears the model state too
    always @(posedge reset) m = '{default: 0};

    // Monitor: compare DUT against queued expectations mid-cycle
    always @(negedge clock) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_mem_ir", mem_ir, e.ir);
            if (!e.sq) begin
                chk("sb_reg_C", reg_C, e.c);
                chk("sb_smdr1", smdr1, e.sd);
            end
            chk1("sb_dw", dw, e.dw);
            chk1("sb_zf", zf, e.zf);
            chk1("sb_nf", nf, e.nf);
            chk1("sb_cf", cf, e.cf);
            chk1("sb_branch", branch_flag, e.bf);
        end
    end

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [10:0] lo);
        return {op, lo};
    endfunction

    // Apply one set of inputs across one clock edge; returns just after the edge
    task automatic cyc(input logic st, input logic [15:0] ir, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] sd);
        state = st; ex_ir = ir; reg_A = a; reg_B = b; smdr = sd;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb, hold_ir;
        logic [4:0]  opv;
        int          k;
        m = '{default: 0};
        reset = 1'b1; state = 1'b0; ex_ir = '0; reg_A = '0; reg_B = '0; smdr = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_mem_ir", mem_ir, 16'h0);
        chk("rst_reg_C", reg_C, 16'h0);
        chk1("rst_cf", cf, 1'b0);
        chk1("rst_branch", branch_flag, 1'b0);

        // Add with carry-out, then ADDC consumes it
        cyc(1'b1, mk(OP_ADD, 11'h123), 16'hFFFF, 16'h0001, 16'h0);
        chk("add_c", reg_C, 16'h0000); chk1("add_zf", zf, 1'b1);
        chk1("add_cf", cf, 1'b1);      chk1("add_nf", nf, 1'b0);
        cyc(1'b1, mk(OP_ADDC, 11'h0), 16'h0000, 16'h0000, 16'h0);
        chk("addc_c", reg_C, 16'h0001); chk1("addc_cf", cf, 1'b0);

        // Borrow, then arithmetic shift keeps cf
        cyc(1'b1, mk(OP_SUB, 11'h0), 16'h0003, 16'h0005, 16'h0);
        chk("sub_c", reg_C, 16'hFFFE); chk1("sub_nf", nf, 1'b1); chk1("sub_cf", cf, 1'b1);
        cyc(1'b1, mk(OP_SRA, 11'h0), 16'h8000, 16'h000F, 16'h0);
        chk("sra_c", reg_C, 16'hFFFF); chk1("sra_cf", cf, 1'b1);

        // Taken branch squashes the next instruction
        cyc(1'b1, mk(OP_CMP, 11'h0), 16'h0005, 16'h0005, 16'h0);
        cyc(1'b1, mk(OP_BZ, 11'h0), 16'h0010, 16'h0004, 16'h0);
        chk1("bz_taken", branch_flag, 1'b1); chk("bz_target", reg_C, 16'h0014);
        cyc(1'b1, mk(OP_ADD, 11'h0), 16'h0001, 16'h0001, 16'h0);
        chk("squash_ir", mem_ir, 16'h0); chk1("squash_branch", branch_flag, 1'b0);
        chk1("squash_zf", zf, 1'b1);
        cyc(1'b1, mk(OP_CMP, 11'h0), 16'h0005, 16'h0005, 16'h0);
        cyc(1'b1, mk(OP_BNZ, 11'h0), 16'h0010, 16'h0004, 16'h0);
        chk1("bnz_not_taken", branch_flag, 1'b0);

        // Store then NOP
        cyc(1'b1, mk(OP_STORE, 11'h0), 16'h0100, 16'h0003, 16'hBEEF);
        chk("st_addr", reg_C, 16'h0103); chk("st_data", smdr1, 16'hBEEF); chk1("st_dw", dw, 1'b1);
        cyc(1'b1, 16'h0000, 16'h0, 16'h0, 16'h0);
        chk1("nop_dw", dw, 1'b0);

        // Asynchronous reset mid-run
        cyc(1'b1, mk(OP_ADD, 11'h0), 16'hFFFF, 16'h0001, 16'h0);
        cyc(1'b1, 16'h1234, 16'h0, 16'h0, 16'h0);
        chk("pre_rst_ir", mem_ir, 16'h1234); chk1("pre_rst_cf", cf, 1'b1);
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        chk("arst_ir", mem_ir, 16'h0); chk("arst_c", reg_C, 16'h0); chk("arst_sd", smdr1, 16'h0);
        chk1("arst_dw", dw, 1'b0); chk1("arst_zf", zf, 1'b0); chk1("arst_nf", nf, 1'b0);
        chk1("arst_cf", cf, 1'b0); chk1("arst_branch", branch_flag, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Idle holds everything; the pending instruction executes exactly once
        hold_ir = mk(OP_ADD, 11'h055);
        cyc(1'b1, hold_ir, 16'hFFFF, 16'h0001, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, mk(OP_SUB, 11'(i)), 16'(i + 7), 16'h0002, 16'h0);
            chk("idle_ir", mem_ir, hold_ir); chk("idle_c", reg_C, 16'h0); chk1("idle_cf", cf, 1'b1);
        end
        cyc(1'b1, mk(OP_ADDC, 11'h0), 16'h0001, 16'h0000, 16'h0);
        chk("resume_c", reg_C, 16'h0002); chk1("resume_cf", cf, 1'b0);
        cyc(1'b0, mk(OP_ADDC, 11'h0), 16'h0001, 16'h0000, 16'h0);
        chk("resume_once", reg_C, 16'h0002);

        // Randomized traffic, including unknown opcodes and idle cycles
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, NOPS + 1);
            if (k < NOPS)       opv = ops[k];
            else if (k == NOPS) opv = 5'd5;
            else                opv = 5'd23;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
            cyc(($urandom_range(0, 4) != 0), mk(opv, 11'($urandom)), ra, rb, 16'($urandom));
        end

        cyc(1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clock);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
